shift_add_mul: RTL and testbench

Sequential unsigned shift-and-add multiply-accumulator computing `p = a*b + c`, the inverse of the restoring divider in the same arithmetic set. Feeding it a quotient, divisor and remainder (`a=q`, `b=divisor`, `c=r`) reconstructs the dividend, which is how the divider is cross-checked. It processes one multiplier bit per clock and uses the same start/busy/ready/count handshake as the divider.

---
 rtl/shift_add_mul.sv | 107 ++++++++++
 tb/tb_shift_add_mul.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mul.sv
// Sequential unsigned multiply-accumulate p = a*b + c.
// One multiplier bit is consumed per clock; handshake matches the restoring divider.
module shift_add_mul #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic [2*WIDTH-1:0] p,
    output logic               busy,
    output logic               ready,
    output logic [CW-1:0]      count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic [2*WIDTH-1:0]   sum;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        p_d      = p_q;
        count_d  = count_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = {{WIDTH{1'b0}}, c};
                    count_d  = '0;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                // Last iteration publishes the sum including this cycle's add.
                if (count_q == LAST) begin
                    p_d     = sum;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    assign p     = p_q;
    assign busy  = busy_q;
    assign ready = ready_q;
    assign count = count_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Randomized self-checking bench for shift_add_mul against an arithmetic model.
// Outputs are sampled 1ns after each rising edge.
module tb_shift_add_mul;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a, b, c;
    logic [2*W-1:0] p;
    logic           busy, ready;
    logic [CW-1:0]  count;

    int n_cmp;
    int n_err;

    shift_add_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .p     (p),
        .busy  (busy),
        .ready (ready),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input int unsigned x, input int unsigned y,
                                             input int unsigned z);
        int unsigned r;
        r = x * y + z;
        return r[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept, then wait the fixed latency and report what the DUT shows.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] z, output logic [2*W-1:0] pr,
                          output logic rdy, output logic bsy);
        a = x; b = y; c = z; start = 1'b1;
        tick();
        start = 1'b0;
        a = '0; b = '0; c = '0;
        repeat (W) tick();
        pr = p; rdy = ready; bsy = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c = '0;
        tick(); tick();
        n_cmp++;
        if (p !== '0) begin n_err++; $display("FAIL reset_p got %0d want 0", p); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", ready); end
        n_cmp++;
        if (count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [2*W-1:0] exp_p;
        int busy_cycles;
        exp_p = model(13, 10, 7);
        busy_cycles = 0;
        a = 8'd13; b = 8'd10; c = 8'd7; start = 1'b1;
        tick();
        start = 1'b0;
        if (busy === 1'b1) busy_cycles++;
        n_cmp++;
        if (busy !== 1'b1 || ready !== 1'b0 || count !== '0) begin
            n_err++;
            $display("FAIL basic_accept got busy=%b ready=%b count=%0d want 1 0 0",
                     busy, ready, count);
        end
        for (int k = 1; k < W; k++) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
            n_cmp++;
            if (count !== CW'(k) || ready !== 1'b0) begin
                n_err++;
                $display("FAIL basic_count got count=%0d ready=%b want %0d 0", count, ready, k);
            end
        end
        tick();
        if (busy === 1'b1) busy_cycles++;
        n_cmp++;
        if (busy_cycles != W) begin
            n_err++;
            $display("FAIL basic_busy_len got %0d want %0d", busy_cycles, W);
        end
        n_cmp++;
        if (p !== exp_p || ready !== 1'b1 || count !== CW'(W - 1)) begin
            n_err++;
            $display("FAIL basic_done got p=%0d ready=%b count=%0d want %0d 1 %0d",
                     p, ready, count, exp_p, W - 1);
        end
        for (int k = 0; k < 20; k++) begin
            tick();
            n_cmp++;
            if (p !== exp_p || ready !== 1'b1 || busy !== 1'b0 || count !== CW'(W - 1)) begin
                n_err++;
                $display("FAIL basic_hold got p=%0d ready=%b busy=%b want %0d 1 0",
                         p, ready, busy, exp_p);
            end
        end
    endtask

    task automatic test_extremes();
        logic [2*W-1:0] pr;
        logic rdy, bsy;
        int unsigned ops [3][3];
        ops = '{'{255, 255, 255}, '{0, 200, 0}, '{1, 1, 0}};
        for (int i = 0; i < 3; i++) begin
            run_op(W'(ops[i][0]), W'(ops[i][1]), W'(ops[i][2]), pr, rdy, bsy);
            n_cmp++;
            if (pr !== model(ops[i][0], ops[i][1], ops[i][2]) || rdy !== 1'b1 || bsy !== 1'b0) begin
                n_err++;
                $display("FAIL extreme_%0d got p=%0d ready=%b busy=%b want %0d 1 0",
                         i, pr, rdy, bsy, model(ops[i][0], ops[i][1], ops[i][2]));
            end
        end
    endtask

    task automatic test_start_mid_calc();
        logic [W-1:0] x, y, z;
        logic [2*W-1:0] exp_p;
        x = W'($urandom); y = W'($urandom); z = W'($urandom);
        exp_p = model(x, y, z);
        a = x; b = y; c = z; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        a = ~x; b = ~y; c = ~z; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (W - 5) tick();
        n_cmp++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_start_early got busy=%b ready=%b want 1 0", busy, ready);
        end
        tick();
        n_cmp++;
        if (p !== exp_p || ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_start_result got p=%0d ready=%b busy=%b want %0d 1 0",
                     p, ready, busy, exp_p);
        end
        for (int k = 0; k < W + 2; k++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0 || ready !== 1'b1 || p !== exp_p) begin
                n_err++;
                $display("FAIL mid_start_no_second got busy=%b ready=%b p=%0d want 0 1 %0d",
                         busy, ready, p, exp_p);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa [4], ob [4], oc [4];
        logic exp_rdy;
        for (int i = 0; i < 4; i++) begin
            oa[i] = W'($urandom); ob[i] = W'($urandom); oc[i] = W'($urandom);
        end
        a = oa[0]; b = ob[0]; c = oc[0]; start = 1'b1;
        for (int t = 0; t < 3 * (W + 1); t++) begin
            tick();
            if (t % (W + 1) == 0) begin
                a = oa[t / (W + 1) + 1];
                b = ob[t / (W + 1) + 1];
                c = oc[t / (W + 1) + 1];
            end
            exp_rdy = (t % (W + 1) == W);
            n_cmp++;
            if (ready !== exp_rdy || (busy & ready) !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ready t=%0d got ready=%b busy=%b want ready=%b",
                         t, ready, busy, exp_rdy);
            end
            if (exp_rdy) begin
                n_cmp++;
                if (p !== model(oa[t / (W + 1)], ob[t / (W + 1)], oc[t / (W + 1)])) begin
                    n_err++;
                    $display("FAIL b2b_p t=%0d got %0d want %0d", t, p,
                             model(oa[t / (W + 1)], ob[t / (W + 1)], oc[t / (W + 1)]));
                end
            end
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] pr;
        logic rdy, bsy;
        a = 8'd200; b = 8'd200; c = 8'd5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if (count !== CW'(4) || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre got count=%0d busy=%b want 4 1", count, busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_cmp++;
        if (p !== '0 || busy !== 1'b0 || ready !== 1'b0 || count !== '0) begin
            n_err++;
            $display("FAIL rst_mid_clear got p=%0d busy=%b ready=%b count=%0d want 0 0 0 0",
                     p, busy, ready, count);
        end
        run_op(8'd7, 8'd9, 8'd0, pr, rdy, bsy);
        n_cmp++;
        if (pr !== 16'd63 || rdy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_after got p=%0d ready=%b want 63 1", pr, rdy);
        end
    endtask

    task automatic test_divider_check();
        logic [2*W-1:0] pr;
        logic rdy, bsy;
        int unsigned x, y, q, r;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom_range(0, 255);
            y = $urandom_range(1, 255);
            q = x / y;
            r = x % y;
            run_op(W'(q), W'(y), W'(r), pr, rdy, bsy);
            n_cmp++;
            if (pr !== (2*W)'(x) || rdy !== 1'b1 || bsy !== 1'b0) begin
                n_err++;
                $display("FAIL div_check q=%0d b=%0d r=%0d got p=%0d ready=%b want %0d 1",
                         q, y, r, pr, rdy, x);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_start_mid_calc();
        test_back_to_back();
        test_reset_mid();
        test_divider_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
